keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Responder-side model of a 4x4 matrix keypad: drives the row lines that a column-scanning keypad scanner reads.
- Accepts 4-bit key codes on a valid/ready interface and buffers them in a small FIFO.
- "Presses" each key for HOLD_CYCLES, then releases it for GAP_CYCLES.
- Used as an on-board loopback target (GPIO-to-GPIO) and as the stimulus model in scanner benches.

Parameters:
- HOLD_CYCLES, 2000, clock cycles a key is held pressed (>=1).
- GAP_CYCLES, 1000, minimum released cycles between consecutive presses (>=1).
- FIFO_DEPTH, 4, key-code queue entries (power of 2, >=2).

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- key_code  in  4  hex key to press (0x0-0xF).
- key_valid  in  1  key_code valid this cycle.
- key_ready  out  1  FIFO can accept; transfer occurs on an edge where valid&ready.
- columns  in  4  scanner column drive; 0 = driven low, 1 = released/pulled up. Bit3 = leftmost column.
- rows  out  4  row lines to scanner; 0 = pulled low through a pressed key, else 1. Bit3 = top row.
- pressed  out  1  a key is currently held.
- cur_key  out  4  key being held/last held.
- press_count  out  8  completed presses, wraps 255->0.

Behaviour:
- Reset values (async on reset_n low): FIFO empty, state IDLE, pressed=0, cur_key=0, press_count=0, key_ready=1, rows=4'b1111 regardless of columns. Reset mid-press aborts immediately; queued keys are discarded.
- Key map, row bit/col bit:
  - 1:(3,3) 2:(3,2) 3:(3,1) A:(3,0)
  - 4:(2,3) 5:(2,2) 6:(2,1) B:(2,0)
  - 7:(1,3) 8:(1,2) 9:(1,1) C:(1,0)
  - E:(0,3) 0:(0,2) F:(0,1) D:(0,0)
- Rows are combinational from columns plus registered state, modelling a physical switch:
  - rows[r] = 0 iff pressed=1, r = row(cur_key), and columns[col(cur_key)] = 0.
  - All other row bits = 1.
  - No clock latency from columns to rows.
- key_ready = FIFO not full. Push when valid&ready; data held in FIFO; no bypass path.
- FSM, one down-counter sized for max(HOLD_CYCLES, GAP_CYCLES):
  - IDLE: if FIFO non-empty: pop, cur_key <= head, counter <= HOLD_CYCLES-1, pressed <= 1, go PRESS.
  - PRESS: if counter==0: pressed <= 0, press_count++, counter <= GAP_CYCLES-1, go GAP; else decrement.
  - GAP: if counter==0 go IDLE; else decrement.
- Latency and timing:
  - Key accepted at edge k into an idle, empty block: pressed=1 from edge k+1.
  - pressed stays high exactly HOLD_CYCLES cycles, then low for exactly GAP_CYCLES cycles.
  - After GAP, one IDLE cycle precedes the next press. Inter-press low time = GAP_CYCLES+1.
- Push and pop on the same edge are both honoured; occupancy is unchanged.
- Full FIFO: key_ready=0, key_valid ignored, no overwrite.
- cur_key holds its last value while released.
- Rows with columns at an illegal multi-zero pattern follow the same rule: only the pressed key's column matters.

Decomposition:
- Shared package keypad_pkg:
  - KEY_ROW[16] / KEY_COL[16] 2-bit lookup constants for the map above (reused by the scanner).
  - State encoding IDLE/PRESS/GAP.
- One sub-module: key_fifo (synchronous FIFO with parameter DEPTH, 4-bit data, async active-low reset, outputs full/empty).

Test Plan:
- Reset hold, columns=4'b0000, reset_n=0 -> rows=1111, key_ready=1, press_count=0; release reset -> unchanged.
- HOLD=4, GAP=3, push 0x5 at edge 10, columns=4'b1011 -> pressed 1 from edge 11 through edge 15, rows=1011; columns=4'b0111 during press -> rows=1111; press_count=1 after edge 15.
- Push 0xD, columns rotating 0111/1011/1101/1110 each cycle -> rows=1110 only while columns=1110 and pressed=1.
- FIFO_DEPTH=4, push 6 keys back-to-back while busy -> key_ready drops after 4 queued plus the one in flight; exactly 5 accepted keys are pressed in order; 6th dropped.
- Assert reset_n low mid-PRESS with 2 keys queued -> rows=1111 same cycle; after release no further presses; pressed=0.
- 256 presses of key 0x0 -> press_count wraps to 0; press/gap widths are constant for every press.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key-code to matrix position map and emulator FSM states.
// The row/column tables are indexed by hex key code and reused by the scanner side.
package keypad_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Entry n gives the row/column bit for key code n (bit 3 = top row / leftmost column).
    localparam logic [1:0] KEY_ROW [16] = '{
        2'd0, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd1, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0
    };

    localparam logic [1:0] KEY_COL [16] = '{
        2'd2, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3,
        2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1
    };

endpackage

// File: rtl/keypad_emulator_if.sv
// Valid/ready key-code handshake into the keypad emulator.
interface keypad_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/key_fifo.sv
// Small synchronous FIFO for 4-bit key codes; pointers carry an extra wrap bit.
module key_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [3:0] din,
    input  logic       pop,
    output logic [3:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/keypad_emulator.sv
// Responder-side 4x4 keypad model: queued key codes are pressed for HOLD_CYCLES, then released
// for GAP_CYCLES; row lines follow the scanner's column drive combinationally like a real switch.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES = 2000,
    parameter int GAP_CYCLES  = 1000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    keypad_emulator_if.slave  key_if,
    input  logic [3:0]        columns,
    output logic [3:0]        rows,
    output logic              pressed,
    output logic [3:0]        cur_key,
    output logic [7:0]        press_count
);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    head;
    logic          full;
    logic          empty;
    logic          pop;

    assign key_if.key_ready = !full;
    assign pop = (state == ST_IDLE) && !empty;

    key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .push  (key_if.key_valid),
        .din   (key_if.key_code),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pressed     <= 1'b0;
            cur_key     <= '0;
            press_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        cur_key <= head;
                        cnt     <= HOLD_LOAD;
                        pressed <= 1'b1;
                        state   <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (cnt == '0) begin
                        pressed     <= 1'b0;
                        press_count <= press_count + 8'd1;
                        cnt         <= GAP_LOAD;
                        state       <= ST_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only the held key's own column can pull its row low, even with several columns driven.
    always_comb begin
        rows = '1;
        if (pressed && !columns[KEY_COL[cur_key]])
            rows[KEY_ROW[cur_key]] = 1'b0;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized scoreboard bench for keypad_emulator with a layout-based reference model.
module tb_keypad_emulator;
    localparam int HOLD  = 4;
    localparam int GAP   = 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] columns = 4'h0;
    logic [3:0] rows;
    logic       pressed;
    logic [3:0] cur_key;
    logic [7:0] press_count;

    keypad_emulator_if kif ();

    keypad_emulator #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLOCK_50    (clk),
        .reset_n     (rst_n),
        .key_if      (kif),
        .columns     (columns),
        .rows        (rows),
        .pressed     (pressed),
        .cur_key     (cur_key),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Physical keypad face, top row first, leftmost column first.
    string LAYOUT = "123A456B789CE0FD";

    logic [3:0] sbq [$];
    bit         in_press = 0;
    bit         backlog = 0;
    bit         seen_any = 0;
    int         high_len = 0;
    int         low_len = 0;
    int         model_count = 0;
    int         presses_done = 0;
    int         pushes_accepted = 0;
    logic [3:0] cur_exp = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [3:0] exp_rows(input logic [3:0] code, input logic [3:0] cols, input bit held);
        logic [3:0] r;
        byte        ch;
        r  = 4'hF;
        ch = (code < 10) ? byte'(8'h30 + code) : byte'(8'h41 + code - 10);
        if (held) begin
            for (int i = 0; i < 16; i++) begin
                if (LAYOUT[i] == ch && cols[3 - (i % 4)] == 1'b0)
                    r[3 - (i / 4)] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] rand_cols();
        logic [3:0] c;
        if ($urandom_range(0, 3) == 0)
            c = 4'($urandom_range(0, 15));
        else
            c = ~(4'b0001 << $urandom_range(0, 3));
        return c;
    endfunction

    // Monitor: pops the expected key on each press and checks widths, counts and rows.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            in_press    = 0;
            backlog     = 0;
            seen_any    = 0;
            high_len    = 0;
            low_len     = 0;
            model_count = 0;
            cur_exp     = 4'h0;
            check("reset_rows", rows, 4'hF);
            check("reset_pressed", pressed, 0);
            check("reset_count", press_count, 0);
            check("reset_ready", kif.key_ready, 1);
        end else begin
            if (pressed && !in_press) begin
                if (sbq.size() == 0) begin
                    flag("unexpected_press");
                end else begin
                    cur_exp = sbq.pop_front();
                    check("key_order", cur_key, cur_exp);
                end
                if (seen_any) begin
                    if (backlog)
                        check("gap_width", low_len, GAP + 1);
                    else
                        check("gap_min", low_len >= GAP + 1, 1);
                end
                in_press = 1;
                seen_any = 1;
                backlog  = 0;
                high_len = 1;
            end else if (pressed) begin
                high_len++;
                if (high_len == HOLD + 1)
                    flag("hold_overrun");
            end else if (in_press) begin
                check("hold_width", high_len, HOLD);
                model_count = (model_count + 1) % 256;
                presses_done++;
                check("press_count", press_count, model_count);
                in_press = 0;
                low_len  = 1;
            end else if (seen_any) begin
                low_len++;
                if (low_len == GAP + 1 && sbq.size() > 0)
                    backlog = 1;
                if (backlog && low_len == GAP + 2)
                    flag("late_press");
            end
            check("rows", rows, exp_rows(cur_exp, columns, in_press));
            check("cur_key", cur_key, cur_exp);
        end
    end

    // One stimulus cycle, entered and left at a falling edge.
    task automatic cycle(input bit v, input logic [3:0] code, input logic [3:0] cols);
        bit exp_ready;
        exp_ready = (sbq.size() < DEPTH);
        if (rst_n)
            check("key_ready", kif.key_ready, exp_ready);
        kif.key_valid = v;
        kif.key_code  = code;
        columns       = cols;
        @(posedge clk);
        if (v && exp_ready && rst_n) begin
            sbq.push_back(code);
            pushes_accepted++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || in_press) && n < 2000) begin
            cycle(0, 4'h0, rand_cols());
            n++;
        end
        if (n >= 2000)
            flag("drain_timeout");
        repeat (GAP + 2) cycle(0, 4'h0, rand_cols());
    endtask

    logic [3:0] burst_keys [6] = '{4'h5, 4'hD, 4'h1, 4'hA, 4'hE, 4'hF};
    logic [3:0] rot_cols   [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    initial begin
        int start;
        int n;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;

        // Reset with every column driven low.
        columns = 4'b0000;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_rows", rows, 4'hF);
        check("hold_ready", kif.key_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rows", rows, 4'hF);
        check("post_count", press_count, 0);

        repeat (300) cycle($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), rand_cols());
        drain();

        // Directed press of key 5 with its column driven, then the column released.
        cycle(1, 4'h5, 4'b1011);
        cycle(0, 4'h0, 4'b1011);
        check("key5_rows", rows, 4'b1011);
        cycle(0, 4'h0, 4'b0111);
        check("key5_released_col", rows, 4'b1111);
        drain();

        // Back-to-back burst of six keys while the first is in flight.
        start = presses_done;
        pushes_accepted = 0;
        for (int i = 0; i < 6; i++)
            cycle(1, burst_keys[i], rot_cols[i % 4]);
        check("burst_accepted", pushes_accepted, 5);
        n = 0;
        while ((sbq.size() != 0 || in_press) && n < 500) begin
            cycle(0, 4'h0, rot_cols[n % 4]);
            n++;
        end
        drain();
        check("burst_presses", presses_done - start, 5);

        // Reset in the middle of a press with two keys still queued.
        for (int i = 0; i < 3; i++)
            cycle(1, 4'(i + 7), 4'b0000);
        n = 0;
        while (!in_press && n < 50) begin
            cycle(0, 4'h0, 4'b0000);
            n++;
        end
        if (n >= 50)
            flag("press_timeout");
        check("pre_reset_rows", rows, exp_rows(cur_exp, 4'b0000, 1));
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("abort_rows", rows, 4'hF);
        check("abort_pressed", pressed, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) cycle(0, 4'h0, 4'b0000);
        check("no_replay", pressed, 0);

        // 256 presses of key 0 to wrap the press counter.
        start = presses_done;
        pushes_accepted = 0;
        n = 0;
        while (pushes_accepted < 256 && n < 5000) begin
            cycle(1, 4'h0, rand_cols());
            n++;
        end
        drain();
        check("wrap_presses", presses_done - start, 256);
        check("wrap_count", press_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
